sram_like_arbiter: RTL
======================

Name: sram_like_arbiter

Overview:
- Parametrised N-channel arbiter that merges NUM_CH sram-like master ports onto one sram-like slave port. Each port carries req/wr/size/wstrb/addr/wdata/addr_ok/data_ok/rdata.
- Successor to the fixed two-port inst/data hookup at the CPU top. It lets the instruction fetch, data, and future cache/PTW masters share one bridge port.
- Tracks in-order outstanding transactions and routes each data_ok back to the master that issued it.

Parameters:
- NUM_CH, 2, number of master channels (1..8).
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- MAX_OUTST, 4, maximum accepted-but-not-returned transactions (power of two, >=2).
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m_req  in  NUM_CH  per-channel request.
- m_wr  in  NUM_CH  per-channel write flag.
- m_size  in  2*NUM_CH  per-channel size (0 = byte, 1 = half, 2 = word), channel i at [2i+1:2i].
- m_wstrb  in  (DW/8)*NUM_CH  per-channel byte strobes.
- m_addr  in  AW*NUM_CH  per-channel address.
- m_wdata  in  DW*NUM_CH  per-channel write data.
- m_addr_ok  out  NUM_CH  per-channel address handshake.
- m_data_ok  out  NUM_CH  per-channel data return.
- m_rdata  out  DW  read data, broadcast to all channels; valid only where m_data_ok is set.
- s_req  out  1  slave request.
- s_wr  out  1  slave write flag.
- s_size  out  2  slave size.
- s_wstrb  out  DW/8  slave byte strobes.
- s_addr  out  AW  slave address.
- s_wdata  out  DW  slave write data.
- s_addr_ok  in  1  slave address handshake.
- s_data_ok  in  1  slave data return.
- s_rdata  in  DW  slave read data.
- outst_cnt  out  $clog2(MAX_OUTST)+1  current outstanding count.
- err_spurious  out  1  sticky; set on s_data_ok while nothing is outstanding.

Behaviour:
- Reset (resetn low, asynchronous) clears the following, effective immediately:
  - outst_cnt = 0, ID FIFO pointers = 0, lock = 0, err_spurious = 0.
  - rr_last = NUM_CH-1, so channel 0 wins first.
- With all m_req = 0: s_req = 0 and all m_addr_ok/m_data_ok = 0.
- Grant selection, combinational, while lock = 0:
  - PRIO_MODE = 0: first requesting channel scanning from rr_last+1 upward, with wrap-around.
  - PRIO_MODE = 1: lowest-index requesting channel.
- Lock:
  - Set when s_req = 1 and s_addr_ok = 0.
  - While lock = 1, the grant is frozen on the locked channel even if a higher-priority request appears, so s_addr/s_wdata stay stable until the handshake.
  - Cleared on the handshake cycle.
- s_req = m_req[grant] && (outst_cnt < MAX_OUTST).
  - When full, s_req = 0 and lock does not set.
  - A pop in the same cycle does not unblock a push (no full-bypass path).
- s_wr/s_size/s_wstrb/s_addr/s_wdata are muxed from the granted channel, zero-latency combinational.
- m_addr_ok[i] = s_req && s_addr_ok && (grant == i).
- Accept (s_req && s_addr_ok):
  - Push grant index into the ID FIFO.
  - rr_last <= grant.
  - outst_cnt += 1, unless a pop occurs in the same cycle.
- Return (s_data_ok):
  - Slave returns strictly in order.
  - If outst_cnt > 0: pop FIFO head h, m_data_ok[h] = 1 in the same cycle, m_rdata = s_rdata, outst_cnt -= 1.
  - If outst_cnt = 0: no pop, no m_data_ok, err_spurious <= 1 (cleared only by reset).
- Simultaneous accept and return: both occur; outst_cnt is unchanged; FIFO pointers wrap modulo MAX_OUTST.
- Writes also occupy a FIFO slot and return m_data_ok (rdata don't-care).
- A master deasserting m_req while locked is a protocol violation; behaviour is not defined beyond holding the lock.

Test Plan:
- Single channel read: m_req[0]=1, addr=0x1C000000, s_addr_ok=1 one cycle, s_data_ok two cycles later with s_rdata=0xDEADBEEF -> m_addr_ok[0] pulses once; m_data_ok[0] pulses with m_rdata=0xDEADBEEF; outst_cnt goes 0->1->0.
- Round-robin fairness: NUM_CH=3, all m_req held high, s_addr_ok=1 always, s_data_ok=1 always -> grant order 0,1,2,0,1,2; each m_data_ok routed to its issuer.
- Lock hold: ch1 requesting with s_addr_ok=0 for 3 cycles; ch0 raises req in cycle 2 under PRIO_MODE=1 -> s_addr stays ch1's address for all 3 cycles; ch1 accepted first, ch0 next.
- Full stall: MAX_OUTST=4, 4 accepts with no s_data_ok -> s_req=0 with m_req high. One s_data_ok -> push still blocked that cycle; s_req=1 the next cycle.
- Simultaneous push/pop with wrap: 10 back-to-back transactions alternating ch0/ch1 with 1-cycle data return -> outst_cnt steady at 1; m_data_ok sequence matches issue order across the pointer wrap.
- Spurious return and async reset: s_data_ok=1 with outst_cnt=0 -> err_spurious=1, no m_data_ok. Then resetn low mid-cycle with 2 outstanding -> outst_cnt=0 and err_spurious=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges NUM_CH sram-like masters onto one slave port.
// In-order ID FIFO routes each data_ok back to the issuing master.
module sram_like_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CH-1:0]            m_req,
  input  logic [NUM_CH-1:0]            m_wr,
  input  logic [2*NUM_CH-1:0]          m_size,
  input  logic [(DW/8)*NUM_CH-1:0]     m_wstrb,
  input  logic [AW*NUM_CH-1:0]         m_addr,
  input  logic [DW*NUM_CH-1:0]         m_wdata,
  output logic [NUM_CH-1:0]            m_addr_ok,
  output logic [NUM_CH-1:0]            m_data_ok,
  output logic [DW-1:0]                m_rdata,
  output logic                         s_req,
  output logic                         s_wr,
  output logic [1:0]                   s_size,
  output logic [DW/8-1:0]              s_wstrb,
  output logic [AW-1:0]                s_addr,
  output logic [DW-1:0]                s_wdata,
  input  logic                         s_addr_ok,
  input  logic                         s_data_ok,
  input  logic [DW-1:0]                s_rdata,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         err_spurious
);

  localparam int SW  = DW / 8;
  localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW  = $clog2(MAX_OUTST);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(MAX_OUTST);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_ch_q, lock_ch_d;
  logic [IDW-1:0] rr_last_q, rr_last_d;
  logic           err_q, err_d;
  logic [IDW-1:0] fifo_q [MAX_OUTST];

  logic [IDW-1:0] rr_gnt, fp_gnt, gnt, head;
  logic           rr_hit, fp_hit;
  logic           accept, pop;
  int             idx;

  always_comb begin
    rr_gnt = '0;
    rr_hit = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(rr_last_q) + k) % NUM_CH;
      if (!rr_hit && m_req[idx]) begin
        rr_hit = 1'b1;
        rr_gnt = IDW'(idx);
      end
    end
    fp_gnt = '0;
    fp_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!fp_hit && m_req[i]) begin
        fp_hit = 1'b1;
        fp_gnt = IDW'(i);
      end
    end
  end

  // A locked grant holds the slave payload stable until addr_ok.
  assign gnt = lock_q ? lock_ch_q :
               (PRIO_MODE == 1) ? fp_gnt : rr_gnt;

  assign s_req   = m_req[gnt] && (cnt_q != FULL);
  assign s_wr    = m_wr[gnt];
  assign s_size  = m_size[int'(gnt)*2 +: 2];
  assign s_wstrb = m_wstrb[int'(gnt)*SW +: SW];
  assign s_addr  = m_addr[int'(gnt)*AW +: AW];
  assign s_wdata = m_wdata[int'(gnt)*DW +: DW];

  assign accept = s_req && s_addr_ok;
  assign pop    = s_data_ok && (cnt_q != '0);
  assign head   = fifo_q[rd_ptr_q];

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_addr_ok[i] = accept && (gnt == IDW'(i));
      m_data_ok[i] = pop && (head == IDW'(i));
    end
  end

  assign m_rdata      = s_rdata;
  assign outst_cnt    = cnt_q;
  assign err_spurious = err_q;

  always_comb begin
    cnt_d     = cnt_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    rr_last_d = rr_last_q;
    err_d     = err_q;
    if (accept && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !accept) cnt_d = cnt_q - 1'b1;
    if (accept) begin
      lock_d    = 1'b0;
      rr_last_d = gnt;
    end else if (s_req) begin
      lock_d    = 1'b1;
      lock_ch_d = gnt;
    end
    if (s_data_ok && (cnt_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      rr_last_q <= IDW'(NUM_CH - 1);
      err_q     <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      rr_last_q <= rr_last_d;
      err_q     <= err_d;
      if (accept) begin
        fifo_q[wr_ptr_q] <= gnt;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule
